tanh_vec_issuer: RTL and testbench

TANH_VEC_ISSUER -- requirements
Module: tanh_vec_issuer

---
 rtl/tanh_vec_issuer_pkg.sv | 32 +++
 rtl/tanh_rsp_scoreboard.sv | 51 +++++
 rtl/tanh_vec_issuer.sv | 105 ++++++++++
 tb/tb_tanh_vec_issuer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_vec_issuer_pkg.sv
// Shared definitions for the tanh vector issuer: element width, request/response
// packet formats and the issuer FSM state type.
`ifndef LSTM_INPUT_BITS
`define LSTM_INPUT_BITS 16
`endif

package tanh_vec_issuer_pkg;

  localparam int DATA_W      = `LSTM_INPUT_BITS;
  localparam int MAX_VEC_LEN = 64;
  localparam int IDX_W       = $clog2(MAX_VEC_LEN);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } tanh_input_packet_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } tanh_output_packet_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/tanh_rsp_scoreboard.sv
// Tracks which result slots have been filled and writes tanh responses into them;
// flags out-of-range or duplicate responses while collection is enabled.
module tanh_rsp_scoreboard
  import tanh_vec_issuer_pkg::*;
#(
  parameter int VEC_LEN = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  tanh_output_packet_t       rsp,
  output logic [VEC_LEN*DATA_W-1:0] vec_out,
  output logic                      all_done,
  output logic                      accepted,
  output logic                      bad
);

  logic [VEC_LEN-1:0] mask_q;
  logic [VEC_LEN-1:0] hit;

  // One-hot slot decode; an out-of-range idx matches no slot.
  always_comb begin
    hit = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      hit[i] = enable && rsp.valid && (rsp.idx == IDX_W'(i));
    end
  end

  assign accepted = |(hit & ~mask_q);
  assign bad      = enable && rsp.valid && !accepted;
  assign all_done = &mask_q;

  // Slot contents are kept across a new start so the last result stays readable.
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q  <= '0;
      vec_out <= '0;
    end else if (clear) begin
      mask_q <= '0;
    end else begin
      for (int i = 0; i < VEC_LEN; i++) begin
        if (hit[i] && !mask_q[i]) begin
          mask_q[i]                    <= 1'b1;
          vec_out[i*DATA_W +: DATA_W]  <= rsp.data;
        end
      end
    end
  end

endmodule

// File: rtl/tanh_vec_issuer.sv
// Issues one vector element per cycle into a tanh pipeline and gathers the
// out-of-order results back into a vector, with a drain timeout.
module tanh_vec_issuer
  import tanh_vec_issuer_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [VEC_LEN*DATA_W-1:0] vec_in,
  output tanh_input_packet_t        tanh_req,
  input  tanh_output_packet_t       tanh_rsp,
  output logic [VEC_LEN*DATA_W-1:0] vec_out,
  output logic                      vec_valid,
  output logic                      busy,
  output logic                      err,
  output issuer_state_t             dbg_state
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  issuer_state_t             state_q, state_d;
  logic [IDX_W-1:0]          cnt_q;
  logic [TMR_W-1:0]          tmr_q;
  logic                      err_q;
  logic [VEC_LEN*DATA_W-1:0] cap_q;
  logic                      start_acc, in_flight, rsp_acc, rsp_bad, all_done, timeout;

  assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign timeout   = (state_q == ST_DRAIN) && !all_done && !rsp_acc && (tmr_q == TMR_LAST);

  tanh_rsp_scoreboard #(.VEC_LEN(VEC_LEN)) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_acc),
    .enable   (in_flight),
    .rsp      (tanh_rsp),
    .vec_out  (vec_out),
    .all_done (all_done),
    .accepted (rsp_acc),
    .bad      (rsp_bad)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (all_done)               state_d = ST_DONE;
        else if (cnt_q == LAST_IDX) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (all_done)     state_d = ST_DONE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DONE:  state_d = start_acc ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        cap_q <= vec_in;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (state_q == ST_ISSUE && cnt_q != LAST_IDX) cnt_q <= cnt_q + 1'b1;
        if (rsp_bad || timeout) err_q <= 1'b1;
      end
      // Idle timer only runs in DRAIN and restarts on every accepted response.
      if (state_q != ST_DRAIN || rsp_acc) tmr_q <= '0;
      else                                tmr_q <= tmr_q + 1'b1;
    end
  end

  always_comb begin
    tanh_req = '0;
    if (state_q == ST_ISSUE) begin
      tanh_req.valid = 1'b1;
      tanh_req.idx   = cnt_q;
      for (int i = 0; i < VEC_LEN; i++) begin
        if (cnt_q == IDX_W'(i)) tanh_req.data = cap_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign vec_valid = (state_q == ST_DONE);
  assign busy      = in_flight;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tanh_vec_issuer.sv
// Bench for tanh_vec_issuer: a queue-based tanh pipeline model returns responses
// in configurable orders; results are compared against values derived from vec_in.
`timescale 1ns/1ps
module tb_tanh_vec_issuer;
  import tanh_vec_issuer_pkg::*;

  localparam int VEC_LEN = 8;
  localparam int TIMEOUT = 32;
  localparam int LAT     = 4;
  localparam int VW      = VEC_LEN * DATA_W;

  localparam int M_CONST   = 0;
  localparam int M_REVERSE = 1;
  localparam int M_DUP     = 2;
  localparam int M_DROP    = 3;
  localparam int M_RANDOM  = 4;
  localparam int M_INORDER = 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                start = 1'b0;
  logic [VW-1:0]       vec_in = '0;
  logic [VW-1:0]       vec_out;
  tanh_input_packet_t  tanh_req;
  tanh_output_packet_t tanh_rsp = '0;
  logic                vec_valid, busy, err;
  issuer_state_t       dbg_state;

  tanh_vec_issuer #(.VEC_LEN(VEC_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .vec_in    (vec_in),
    .tanh_req  (tanh_req),
    .tanh_rsp  (tanh_rsp),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  typedef struct {
    int                due;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              pending[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] vec_elem[VEC_LEN];
  logic [DATA_W-1:0] exp_val;

  int tests_run = 0;
  int tests_failed = 0;
  int vv_count, vv_cycle, issue_n, issue_bad, err_rise, last_rsp_cycle;
  logic snap_zero;

  // What the pipeline model returns for element idx whose issued data was x.
  function automatic logic [DATA_W-1:0] model_rsp(input int mode, input int idx,
                                                  input logic [DATA_W-1:0] x);
    case (mode)
      M_CONST:   return 16'h00C3;
      M_REVERSE: return DATA_W'(16'h0010 + idx);
      default:   return x ^ 16'h5A5A;
    endcase
  endfunction

  task automatic randomize_vec();
    for (int i = 0; i < VEC_LEN; i++) vec_elem[i] = DATA_W'($urandom_range(0, 16'hFFFF));
  endtask

  // driver: start pulse at cycle 0, then per-cycle sampling and response injection
  task automatic run_vector(input int mode, input int restart_cycle, input int reset_cycle,
                            input int max_cycles);
    int prev_issue;
    int q_idx;
    logic [DATA_W-1:0] held[VEC_LEN];
    pending.delete();
    vv_count = 0; vv_cycle = -1; issue_n = 0; issue_bad = 0;
    err_rise = -1; last_rsp_cycle = -1; snap_zero = 1'b0; prev_issue = -1;
    for (int i = 0; i < VEC_LEN; i++) held[i] = '0;
    for (int i = 0; i < VEC_LEN; i++) vec_in[i*DATA_W +: DATA_W] = vec_elem[i];
    @(negedge clock);
    start = 1'b1;
    tanh_rsp = '0;
    for (int k = 1; k <= max_cycles; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == reset_cycle + 1) begin
        snap_zero = (tanh_req === '0) && (vec_out === '0) && (vec_valid === 1'b0) &&
                    (busy === 1'b0) && (err === 1'b0) && (dbg_state === ST_IDLE);
        reset = 1'b0;
      end
      if (vec_valid === 1'b1) begin vv_count++; vv_cycle = k; end
      if (err === 1'b1 && err_rise < 0) err_rise = k;
      if (tanh_req.valid === 1'b1) begin
        if (issue_n >= VEC_LEN) issue_bad++;
        else if (tanh_req.idx !== IDX_W'(issue_n) || tanh_req.data !== vec_elem[issue_n] ||
                 busy !== 1'b1 || (issue_n > 0 && k != prev_issue + 1)) issue_bad++;
        q_idx = int'(tanh_req.idx);
        if (q_idx < VEC_LEN) begin
          case (mode)
            M_REVERSE: begin
              held[q_idx] = tanh_req.data;
              if (q_idx == VEC_LEN - 1)
                for (int j = VEC_LEN - 1; j >= 0; j--)
                  pending.push_back('{k + 1, IDX_W'(j), model_rsp(mode, j, held[j])});
            end
            M_DROP: if (q_idx != 5)
              pending.push_back('{k + LAT, tanh_req.idx, model_rsp(mode, q_idx, tanh_req.data)});
            M_DUP: begin
              pending.push_back('{k + LAT, tanh_req.idx, model_rsp(mode, q_idx, tanh_req.data)});
              if (q_idx == 3) begin
                pending.push_back('{k + LAT, tanh_req.idx, ~model_rsp(mode, q_idx, tanh_req.data)});
                pending.push_back('{k + LAT, IDX_W'(9), 16'h1234});
              end
            end
            M_RANDOM:
              pending.push_back('{k + $urandom_range(1, 8), tanh_req.idx,
                                  model_rsp(mode, q_idx, tanh_req.data)});
            default:
              pending.push_back('{k + LAT, tanh_req.idx, model_rsp(mode, q_idx, tanh_req.data)});
          endcase
        end
        prev_issue = k;
        issue_n++;
      end else if (tanh_req !== '0) begin
        issue_bad++;
      end
      // pipeline model output: first due entry in queue order, one per cycle
      tanh_rsp = '0;
      for (int p = 0; p < pending.size(); p++) begin
        if (pending[p].due <= k) begin
          tanh_rsp.valid = 1'b1;
          tanh_rsp.idx   = pending[p].idx;
          tanh_rsp.data  = pending[p].data;
          pending.delete(p);
          last_rsp_cycle = k;
          break;
        end
      end
      if (k == restart_cycle) start = 1'b1;
      if (k == reset_cycle) reset = 1'b1;
    end
    tanh_rsp = '0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tanh_rsp = '0; vec_in = '0;
    repeat (3) @(negedge clock);
    tests_run++; if (tanh_req !== '0) begin tests_failed++; $display("FAIL reset_req: got %h expected 0", tanh_req); end
    tests_run++; if (vec_out !== '0) begin tests_failed++; $display("FAIL reset_vec_out: got %h expected 0", vec_out); end
    tests_run++; if (vec_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got vv=%b busy=%b err=%b expected 0 0 0", vec_valid, busy, err); end
    tests_run++; if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_in_order();
    for (int i = 0; i < VEC_LEN; i++) vec_elem[i] = 16'h0100;
    run_vector(M_CONST, -1, -1, 30);
    tests_run++; if (issue_bad !== 0 || issue_n !== VEC_LEN) begin
      tests_failed++; $display("FAIL inorder_issue: got bad=%0d count=%0d expected 0 %0d", issue_bad, issue_n, VEC_LEN); end
    tests_run++; if (vv_count !== 1) begin tests_failed++; $display("FAIL inorder_vv_count: got %0d expected 1", vv_count); end
    tests_run++; if (vv_cycle !== VEC_LEN + LAT + 2) begin
      tests_failed++; $display("FAIL inorder_latency: got %0d expected %0d", vv_cycle, VEC_LEN + LAT + 2); end
    tests_run++; if (err !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL inorder_end: got err=%b state=%0d expected 0 %0d", err, dbg_state, ST_IDLE); end
    for (int i = 0; i < VEC_LEN; i++) exp_q.push_back(16'h00C3);
    for (int i = 0; i < VEC_LEN; i++) begin
      exp_val = exp_q.pop_front(); tests_run++;
      if (vec_out[i*DATA_W +: DATA_W] !== exp_val) begin
        tests_failed++; $display("FAIL inorder_slot%0d: got %h expected %h", i, vec_out[i*DATA_W +: DATA_W], exp_val); end
    end
  endtask

  task automatic test_reverse();
    randomize_vec();
    run_vector(M_REVERSE, -1, -1, 40);
    tests_run++; if (vv_count !== 1 || err !== 1'b0) begin
      tests_failed++; $display("FAIL reverse_done: got vv=%0d err=%b expected 1 0", vv_count, err); end
    for (int i = 0; i < VEC_LEN; i++) exp_q.push_back(DATA_W'(16'h0010 + i));
    for (int i = 0; i < VEC_LEN; i++) begin
      exp_val = exp_q.pop_front(); tests_run++;
      if (vec_out[i*DATA_W +: DATA_W] !== exp_val) begin
        tests_failed++; $display("FAIL reverse_slot%0d: got %h expected %h", i, vec_out[i*DATA_W +: DATA_W], exp_val); end
    end
  endtask

  task automatic test_duplicate();
    randomize_vec();
    run_vector(M_DUP, -1, -1, 40);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL dup_err: got %b expected 1", err); end
    tests_run++; if (vv_count !== 1) begin tests_failed++; $display("FAIL dup_vv_count: got %0d expected 1", vv_count); end
    for (int i = 0; i < VEC_LEN; i++) exp_q.push_back(vec_elem[i] ^ 16'h5A5A);
    for (int i = 0; i < VEC_LEN; i++) begin
      exp_val = exp_q.pop_front(); tests_run++;
      if (vec_out[i*DATA_W +: DATA_W] !== exp_val) begin
        tests_failed++; $display("FAIL dup_slot%0d: got %h expected %h", i, vec_out[i*DATA_W +: DATA_W], exp_val); end
    end
  endtask

  task automatic test_timeout();
    randomize_vec();
    run_vector(M_DROP, -1, -1, 60);
    tests_run++; if (vv_count !== 0) begin tests_failed++; $display("FAIL timeout_vv: got %0d expected 0", vv_count); end
    tests_run++; if (err_rise < last_rsp_cycle + TIMEOUT || err_rise > last_rsp_cycle + TIMEOUT + 1) begin
      tests_failed++; $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d",
                               err_rise - last_rsp_cycle, TIMEOUT, TIMEOUT + 1); end
    tests_run++; if (err !== 1'b1 || dbg_state !== ST_IDLE || busy !== 1'b0) begin
      tests_failed++; $display("FAIL timeout_end: got err=%b state=%0d busy=%b expected 1 %0d 0", err, dbg_state, busy, ST_IDLE); end
    randomize_vec();
    run_vector(M_INORDER, -1, -1, 30);
    tests_run++; if (err_rise !== -1 || err !== 1'b0 || vv_count !== 1) begin
      tests_failed++; $display("FAIL timeout_recover: got err_rise=%0d err=%b vv=%0d expected -1 0 1", err_rise, err, vv_count); end
  endtask

  task automatic test_start_ignored();
    randomize_vec();
    run_vector(M_INORDER, 3, -1, 30);
    tests_run++; if (issue_bad !== 0 || issue_n !== VEC_LEN) begin
      tests_failed++; $display("FAIL restart_issue: got bad=%0d count=%0d expected 0 %0d", issue_bad, issue_n, VEC_LEN); end
    tests_run++; if (vv_count !== 1 || vv_cycle !== VEC_LEN + LAT + 2) begin
      tests_failed++; $display("FAIL restart_done: got vv=%0d at %0d expected 1 at %0d", vv_count, vv_cycle, VEC_LEN + LAT + 2); end
    for (int i = 0; i < VEC_LEN; i++) exp_q.push_back(vec_elem[i] ^ 16'h5A5A);
    for (int i = 0; i < VEC_LEN; i++) begin
      exp_val = exp_q.pop_front(); tests_run++;
      if (vec_out[i*DATA_W +: DATA_W] !== exp_val) begin
        tests_failed++; $display("FAIL restart_slot%0d: got %h expected %h", i, vec_out[i*DATA_W +: DATA_W], exp_val); end
    end
  endtask

  task automatic test_reset_in_drain();
    randomize_vec();
    run_vector(M_INORDER, -1, 10, 30);
    tests_run++; if (snap_zero !== 1'b1) begin tests_failed++; $display("FAIL drain_reset_zero: got %b expected 1", snap_zero); end
    tests_run++; if (vv_count !== 0 || err_rise !== -1) begin
      tests_failed++; $display("FAIL drain_reset_stale: got vv=%0d err_rise=%0d expected 0 -1", vv_count, err_rise); end
    tests_run++; if (dbg_state !== ST_IDLE || err !== 1'b0) begin
      tests_failed++; $display("FAIL drain_reset_end: got state=%0d err=%b expected %0d 0", dbg_state, err, ST_IDLE); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      randomize_vec();
      run_vector(M_RANDOM, -1, -1, 50);
      tests_run++; if (vv_count !== 1 || err !== 1'b0 || issue_bad !== 0) begin
        tests_failed++; $display("FAIL random%0d_done: got vv=%0d err=%b bad=%0d expected 1 0 0", n, vv_count, err, issue_bad); end
      for (int i = 0; i < VEC_LEN; i++) exp_q.push_back(vec_elem[i] ^ 16'h5A5A);
      for (int i = 0; i < VEC_LEN; i++) begin
        exp_val = exp_q.pop_front(); tests_run++;
        if (vec_out[i*DATA_W +: DATA_W] !== exp_val) begin
          tests_failed++; $display("FAIL random%0d_slot%0d: got %h expected %h", n, i, vec_out[i*DATA_W +: DATA_W], exp_val); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reverse();
    test_duplicate();
    test_timeout();
    test_start_ignored();
    test_reset_in_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
